vga_frame_capture: RTL and testbench

- Receive-side counterpart of the GPU's VGA output; decodes the HS/VS/RGB332 stream back into addressed pixels.
- Tracks sync edges, reconstructs X/Y, and emits one write per visible pixel for a capture RAM or scoreboard.
- Checks line and frame timing against the configured mode and flags violations.
- Sits in GPU test harnesses and capture paths, driven by the same pixel-rate enable as the GPU.

---
 rtl/vga_frame_capture.sv | 198 +++++++++++++++++++
 tb/tb_vga_frame_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: receive side of the VGA output. Recovers pixel coordinates from the
// HS/VS/RGB332 stream, emits one write strobe per visible pixel and flags line/frame
// timing that disagrees with the configured mode.
module vga_frame_capture #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned H_TOTAL   = 800,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned V_TOTAL   = 525,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PixEn,
    input  logic [2:0] Red,
    input  logic [2:0] Green,
    input  logic [1:0] Blue,
    input  logic       HS,
    input  logic       VS,
    input  logic       ClrErr,
    output logic       PixValid,
    output logic [9:0] PixX,
    output logic [8:0] PixY,
    output logic [7:0] PixData,
    output logic       FrameDone,
    output logic       Locked,
    output logic [7:0] FrameCount,
    output logic       LineErr,
    output logic       FrameErr
);

    localparam logic [0:0] StWaitVs = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    localparam logic [10:0] HBeg  = 11'(H_BACK);
    localparam logic [10:0] HEnd  = 11'(H_BACK + H_VISIBLE);
    localparam logic [11:0] HTot  = 12'(H_TOTAL);
    localparam logic [9:0]  VBeg  = 10'(V_BACK);
    localparam logic [9:0]  VEnd  = 10'(V_BACK + V_VISIBLE);
    localparam logic [10:0] VTot  = 11'(V_TOTAL);
    localparam logic [9:0]  XLast = 10'(H_VISIBLE - 1);
    localparam logic [8:0]  YLast = 9'(V_VISIBLE - 1);

    logic [0:0]  state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  lcnt_q, lcnt_d;
    logic [9:0]  edges_q, edges_d;
    logic        hvalid_q, hvalid_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [8:0]  pix_y_q, pix_y_d;
    logic [7:0]  pix_data_q, pix_data_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;

    logic        hs_tr, vs_tr, visible, line_err_set, frame_err_set;
    logic [10:0] edges_sum;
    logic [9:0]  x_off;
    logic [8:0]  y_off;

    // Edge detection, position counters, lock FSM, timing checks and pixel outputs
    always_comb begin
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        edges_d       = edges_q;
        hvalid_d      = hvalid_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_data_d    = pix_data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        line_err_set  = 1'b0;
        frame_err_set = 1'b0;

        // Trailing edge: inactive now, active on the previous enabled sample
        hs_tr = PixEn && (HS != SYNC_POL) && (hs_prev_q == SYNC_POL);
        vs_tr = PixEn && (VS != SYNC_POL) && (vs_prev_q == SYNC_POL);

        // Includes an HS edge landing on the same sample as the VS edge
        edges_sum = {1'b0, edges_q} + {10'd0, hs_tr};

        if (PixEn) begin
            hs_prev_d = HS;
            vs_prev_d = VS;

            if (hs_tr) begin
                hcnt_d = 11'd0;
            end else if (hcnt_q != 11'h7FF) begin
                hcnt_d = hcnt_q + 11'd1;
            end

            if (vs_tr) begin
                lcnt_d = 10'd0;
            end else if (hs_tr && (lcnt_q != 10'h3FF)) begin
                lcnt_d = lcnt_q + 10'd1;
            end
        end

        // Position checks use the counters after this sample's update
        visible = (hcnt_d >= HBeg) && (hcnt_d < HEnd) && (lcnt_d >= VBeg) && (lcnt_d < VEnd);
        x_off   = 10'(hcnt_d - HBeg);
        y_off   = 9'(lcnt_d - VBeg);

        if (PixEn) begin
            if (state_q == StWaitVs) begin
                if (vs_tr) begin
                    state_d  = StActive;
                    edges_d  = 10'd0;
                    hvalid_d = 1'b0;
                end
            end else begin
                if (hs_tr) begin
                    hvalid_d = 1'b1;
                    if (hvalid_q && (({1'b0, hcnt_q} + 12'd1) != HTot)) begin
                        line_err_set = 1'b1;
                    end
                end

                if (vs_tr) begin
                    frame_count_d = frame_count_q + 8'd1;
                    frame_err_set = (edges_sum != VTot);
                    edges_d       = 10'd0;
                end else begin
                    edges_d = edges_sum[10] ? 10'h3FF : edges_sum[9:0];
                end

                if (visible) begin
                    pix_valid_d  = 1'b1;
                    pix_x_d      = x_off;
                    pix_y_d      = y_off;
                    pix_data_d   = {Red, Green, Blue};
                    frame_done_d = (x_off == XLast) && (y_off == YLast);
                end
            end
        end

        // A fresh error outranks a clear in the same cycle
        line_err_d  = line_err_set || (line_err_q && !ClrErr);
        frame_err_d = frame_err_set || (frame_err_q && !ClrErr);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= StWaitVs;
            hs_prev_q     <= ~SYNC_POL;
            vs_prev_q     <= ~SYNC_POL;
            hcnt_q        <= 11'd0;
            lcnt_q        <= 10'd0;
            edges_q       <= 10'd0;
            hvalid_q      <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 9'd0;
            pix_data_q    <= 8'd0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 8'd0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            edges_q       <= edges_d;
            hvalid_q      <= hvalid_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign PixValid   = pix_valid_q;
    assign PixX       = pix_x_q;
    assign PixY       = pix_y_q;
    assign PixData    = pix_data_q;
    assign FrameDone  = frame_done_q;
    assign Locked     = (state_q == StActive);
    assign FrameCount = frame_count_q;
    assign LineErr    = line_err_q;
    assign FrameErr   = frame_err_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed bench for vga_frame_capture in a tiny 4x3 video mode.
module tb_vga_frame_capture;

    logic       Clk = 1'b0;
    logic       Reset_n, PixEn, HS, VS, ClrErr;
    logic [2:0] Red, Green;
    logic [1:0] Blue;
    logic       PixValid, FrameDone, Locked, LineErr, FrameErr;
    logic [9:0] PixX;
    logic [8:0] PixY;
    logic [7:0] PixData, FrameCount;

    vga_frame_capture #(
        .H_VISIBLE(4), .H_BACK(2), .H_TOTAL(10),
        .V_VISIBLE(3), .V_BACK(1), .V_TOTAL(6), .SYNC_POL(1'b0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PixEn(PixEn), .Red(Red), .Green(Green), .Blue(Blue),
        .HS(HS), .VS(VS), .ClrErr(ClrErr), .PixValid(PixValid), .PixX(PixX), .PixY(PixY),
        .PixData(PixData), .FrameDone(FrameDone), .Locked(Locked), .FrameCount(FrameCount),
        .LineErr(LineErr), .FrameErr(FrameErr)
    );

    always #5 Clk = ~Clk;

    // Input sample (line, sample-in-line, rgb) and the pixel write it must produce
    typedef struct {
        int         line;
        int         samp;
        logic [7:0] rgb;
        logic [9:0] x;
        logic [8:0] y;
        logic       done;
    } vec_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] d;
        logic       done;
    } pix_t;

    vec_t vtab[12];
    pix_t cap_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   fd_cnt = 0;
    int   stray_fd = 0;
    int   wide_cnt = 0;
    logic pv_prev = 1'b0;
    bit   gap = 1'b0;

    // Log every pixel write seen by the capture side
    always @(negedge Clk) begin
        pix_t p;
        if (PixValid) begin
            p.x = PixX; p.y = PixY; p.d = PixData; p.done = FrameDone;
            cap_q.push_back(p);
        end
        if (FrameDone) fd_cnt++;
        if (FrameDone && !PixValid) stray_fd++;
        if (PixValid && pv_prev) wide_cnt++;
        pv_prev = PixValid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pix_in(input int l, input int s);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 0; i < 12; i++) if (vtab[i].line == l && vtab[i].samp == s) r = vtab[i].rgb;
        return r;
    endfunction

    // One enabled sample; in gap mode a disabled cycle with scrambled inputs follows
    task automatic drive(input logic hs, input logic vs, input logic [7:0] rgb);
        HS = hs; VS = vs; {Red, Green, Blue} = rgb; PixEn = 1'b1;
        @(posedge Clk); #1;
        if (gap) begin
            PixEn = 1'b0; HS = ~hs; VS = ~vs; {Red, Green, Blue} = ~rgb;
            @(posedge Clk); #1;
        end
    endtask

    // HS low on sample 0 of each line; VS low on sample 0 of line 0
    task automatic send_samples(input int l, input int lo, input int hi);
        for (int s = lo; s <= hi; s++)
            drive((s == 0) ? 1'b0 : 1'b1, (l == 0 && s == 0) ? 1'b0 : 1'b1, pix_in(l, s));
    endtask

    task automatic send_line(input int l, input int len);
        send_samples(l, 0, len - 1);
    endtask

    task automatic send_frame();
        for (int l = 0; l < 6; l++) send_line(l, 10);
    endtask

    task automatic clear_pulse();
        PixEn = 1'b0; ClrErr = 1'b1;
        @(posedge Clk); #1;
        ClrErr = 1'b0;
        @(negedge Clk);
    endtask

    task automatic check_frames(input string tag, input int nf);
        check({tag, "_count"}, cap_q.size(), 12 * nf);
        for (int i = 0; i < cap_q.size() && i < 12 * nf; i++)
            check($sformatf("%s_pix%0d", tag, i),
                  {cap_q[i].x, cap_q[i].y, cap_q[i].d, cap_q[i].done},
                  {vtab[i % 12].x, vtab[i % 12].y, vtab[i % 12].rgb, vtab[i % 12].done});
    endtask

    initial begin
        vtab[0]  = '{1, 3, 8'd0,  10'd0, 9'd0, 1'b0};
        vtab[1]  = '{1, 4, 8'd1,  10'd1, 9'd0, 1'b0};
        vtab[2]  = '{1, 5, 8'd2,  10'd2, 9'd0, 1'b0};
        vtab[3]  = '{1, 6, 8'd3,  10'd3, 9'd0, 1'b0};
        vtab[4]  = '{2, 3, 8'd4,  10'd0, 9'd1, 1'b0};
        vtab[5]  = '{2, 4, 8'd5,  10'd1, 9'd1, 1'b0};
        vtab[6]  = '{2, 5, 8'd6,  10'd2, 9'd1, 1'b0};
        vtab[7]  = '{2, 6, 8'd7,  10'd3, 9'd1, 1'b0};
        vtab[8]  = '{3, 3, 8'd8,  10'd0, 9'd2, 1'b0};
        vtab[9]  = '{3, 4, 8'd9,  10'd1, 9'd2, 1'b0};
        vtab[10] = '{3, 5, 8'd10, 10'd2, 9'd2, 1'b0};
        vtab[11] = '{3, 6, 8'd11, 10'd3, 9'd2, 1'b1};

        // Reset with syncs inactive
        Reset_n = 1'b0; PixEn = 1'b1; HS = 1'b1; VS = 1'b1; ClrErr = 1'b0;
        {Red, Green, Blue} = 8'h00;
        repeat (5) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("rst_pixvalid", PixValid, 0);
        check("rst_pixx", PixX, 0);
        check("rst_pixy", PixY, 0);
        check("rst_pixdata", PixData, 0);
        check("rst_framedone", FrameDone, 0);
        check("rst_locked", Locked, 0);
        check("rst_framecount", FrameCount, 0);
        check("rst_lineerr", LineErr, 0);
        check("rst_frameerr", FrameErr, 0);
        Reset_n = 1'b1;

        // Lines before any VS edge produce nothing
        cap_q.delete();
        for (int l = 1; l < 6; l++) send_line(l, 10);
        @(negedge Clk);
        check("prelock_pix", cap_q.size(), 0);
        check("prelock_locked", Locked, 0);

        // Two clean frames
        cap_q.delete(); fd_cnt = 0; stray_fd = 0;
        send_frame();
        @(negedge Clk);
        check("t2_locked", Locked, 1);
        check("t2_fc0", FrameCount, 0);
        send_frame();
        @(negedge Clk);
        check("t2_fc1", FrameCount, 1);
        send_line(0, 10);
        @(negedge Clk);
        check("t2_fc2", FrameCount, 2);
        check_frames("t2", 2);
        check("t2_fd_cnt", fd_cnt, 2);
        check("t2_fd_stray", stray_fd, 0);
        check("t2_lineerr", LineErr, 0);
        check("t2_frameerr", FrameErr, 0);

        // Short line 2 (9 samples) is flagged at the HS edge that ends it
        send_line(1, 10);
        send_line(2, 9);
        send_samples(3, 0, 0);
        @(negedge Clk);
        check("t3_lineerr_before", LineErr, 0);
        send_samples(3, 1, 1);
        @(negedge Clk);
        check("t3_lineerr_set", LineErr, 1);
        clear_pulse();
        check("t3_lineerr_clr", LineErr, 0);
        check("t3_still_locked", Locked, 1);
        send_samples(3, 2, 9);
        send_line(4, 10);
        send_line(5, 10);
        send_line(0, 10);
        @(negedge Clk);
        check("t3_lineerr_stays", LineErr, 0);
        check("t3_frameerr", FrameErr, 0);
        check("t3_fc3", FrameCount, 3);

        // Seven HS edges in a frame; ClrErr on the same sample must lose
        for (int l = 1; l < 7; l++) send_line(l, 10);
        @(negedge Clk);
        check("t4_frameerr_before", FrameErr, 0);
        send_samples(0, 0, 0);
        ClrErr = 1'b1;
        send_samples(0, 1, 1);
        ClrErr = 1'b0;
        @(negedge Clk);
        check("t4_frameerr_set", FrameErr, 1);
        check("t4_fc4", FrameCount, 4);
        check("t4_lineerr", LineErr, 0);
        send_samples(0, 2, 9);
        clear_pulse();
        check("t4_frameerr_clr", FrameErr, 0);

        // Same stimulus as the clean-frame run with PixEn every other cycle
        Reset_n = 1'b0; PixEn = 1'b1; HS = 1'b1; VS = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        gap = 1'b1;
        cap_q.delete(); fd_cnt = 0; stray_fd = 0; wide_cnt = 0;
        for (int l = 1; l < 6; l++) send_line(l, 10);
        send_frame();
        send_frame();
        @(negedge Clk);
        check("t5_fc1", FrameCount, 1);
        send_line(0, 10);
        @(negedge Clk);
        check("t5_fc2", FrameCount, 2);
        check_frames("t5", 2);
        check("t5_fd_cnt", fd_cnt, 2);
        check("t5_fd_stray", stray_fd, 0);
        check("t5_wide", wide_cnt, 0);
        check("t5_errs", {LineErr, FrameErr}, 0);
        gap = 1'b0;

        // Reset while pixel (2,1) is on the outputs
        send_line(1, 10);
        send_samples(2, 0, 5);
        @(negedge Clk);
        check("t6_pix21", {PixValid, PixX, PixY}, {1'b1, 10'd2, 9'd1});
        Reset_n = 1'b0; HS = 1'b1; VS = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("t6_rst_out", {PixValid, PixX, PixY, PixData, FrameDone}, 0);
        check("t6_rst_locked", Locked, 0);
        check("t6_rst_fc", FrameCount, 0);
        Reset_n = 1'b1;
        cap_q.delete();
        send_samples(2, 6, 9);
        for (int l = 3; l < 6; l++) send_line(l, 10);
        @(negedge Clk);
        check("t6_no_pix", cap_q.size(), 0);
        check("t6_unlocked", Locked, 0);
        send_frame();
        @(negedge Clk);
        check_frames("t6", 1);
        check("t6_locked", Locked, 1);
        check("t6_fc", FrameCount, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
